prog_sequencer: RTL and testbench

Launch and completion controller sitting directly upstream of the program counter. Converts the testbench `Start` handshake into absolute PC loads at per-program base addresses, gates core execution while a program runs, detects the halt instruction and reports `Done`. Sequences through `NPROG` programs in order, with an optional cycle-count watchdog.

---
 rtl/prog_sequencer.sv | 154 +++++++++++++++
 tb/tb_prog_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Purpose: launch/completion controller upstream of the PC; loads per-program bases, gates the core, detects halt.
// Latency: PcLoad/PcTarget/CoreEn are combinational; Done/Timeout/ProgIdx/CycleCount update one edge after the event.
// Backpressure: none; holding Start high keeps the next program armed with the PC parked at its base.
//
// Ports:
//   Clk, Reset (async active-low), Start    - control inputs
//   Pc, Instr                               - current PC value and the instruction fetched there
//   PcLoad, PcTarget                        - absolute-jump request into the PC (target is 0 when idle)
//   CoreEn                                  - core state-update enable, high only while running
//   Done, Timeout, ProgIdx, CycleCount      - registered status
// Optional feature: define SEQ_TIMEOUT_EN to enable the cycle-count watchdog (TIMEOUT); otherwise Timeout is 0.

module prog_sequencer #(
  parameter int unsigned    L       = 10,
  parameter int unsigned    W       = 9,
  parameter int unsigned    NPROG   = 3,
  parameter int unsigned    BASE0   = 50,
  parameter int unsigned    BASE1   = 150,
  parameter int unsigned    BASE2   = 250,
  parameter int unsigned    BASE3   = 0,
  parameter logic [W-1:0]   HALT_OP = 9'h1FF,
  parameter logic [15:0]    TIMEOUT = 16'd4000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [L-1:0]  Pc,
  input  logic [W-1:0]  Instr,
  output logic          PcLoad,
  output logic [L-1:0]  PcTarget,
  output logic          CoreEn,
  output logic          Done,
  output logic          Timeout,
  output logic [1:0]    ProgIdx,
  output logic [15:0]   CycleCount
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NPROG - 1);

  state_t state_q;
  state_t state_d;
  logic   halt;
  logic   wd_hit;

  assign halt = (Instr == HALT_OP);

`ifdef SEQ_TIMEOUT_EN
  // Fires on the edge where the count would reach TIMEOUT, so the final
  // CycleCount equals TIMEOUT.
  assign wd_hit = (CycleCount == (TIMEOUT - 16'd1));
`else
  logic unused_timeout;
  assign wd_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Unused indices decode to 0 even though ProgIdx never reaches them.
  function automatic logic [L-1:0] base_of(input logic [1:0] idx);
    logic [L-1:0] b;
    b = '0;
    if (32'(idx) < NPROG) begin
      case (idx)
        2'd0:    b = L'(BASE0);
        2'd1:    b = L'(BASE1);
        2'd2:    b = L'(BASE2);
        default: b = L'(BASE3);
      endcase
    end
    return b;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    PcLoad   = 1'b0;
    PcTarget = '0;
    CoreEn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) state_d = ARMED;
      end
      ARMED: begin
        // Re-load the base every cycle so the PC is parked until Start drops.
        PcLoad   = 1'b1;
        PcTarget = base_of(ProgIdx);
        if (!Start) state_d = RUN;
      end
      RUN: begin
        CoreEn = 1'b1;
        // Halt beats the watchdog and an abort request in the same cycle.
        if (halt) begin
          PcLoad   = 1'b1;
          PcTarget = Pc;
          state_d  = DONE;
        end else if (wd_hit) begin
          state_d = DONE;
        end else if (Start) begin
          state_d = ARMED;
        end
      end
      DONE: begin
        PcLoad   = 1'b1;
        PcTarget = Pc;
        if (Start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Done       <= 1'b0;
      ProgIdx    <= 2'd0;
      CycleCount <= 16'd0;
    end else begin
      if (state_q == ARMED && state_d == RUN) begin
        CycleCount <= 16'd0;
      end else if (state_q == RUN && CycleCount != 16'hFFFF) begin
        CycleCount <= CycleCount + 16'd1;
      end

      if (state_q == RUN && state_d == DONE) begin
        Done    <= 1'b1;
        ProgIdx <= (ProgIdx == LAST_IDX) ? 2'd0 : ProgIdx + 2'd1;
      end else if (state_q == DONE && state_d == ARMED) begin
        Done <= 1'b0;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Timeout <= 1'b0;
    end else if (state_q == RUN && state_d == DONE) begin
      Timeout <= !halt;
    end else if (state_q == DONE && state_d == ARMED) begin
      Timeout <= 1'b0;
    end
  end
`else
  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Purpose: directed-vector bench for prog_sequencer with a behavioural PC and a run/done scoreboard.
// Latency: expectations are queued before each launch and popped on CoreEn/Done rising edges.
// Backpressure: none; Start is driven directly from the stimulus process.

module tb_prog_sequencer;

  localparam int L = 10;
  localparam int W = 9;
  localparam logic [W-1:0] HALT = 9'h1FF;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] cc;
    logic [9:0]  pc;
    logic        to;
  } done_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [L-1:0]  Pc = '0;
  logic [W-1:0]  Instr;
  logic          PcLoad;
  logic [L-1:0]  PcTarget;
  logic          CoreEn;
  logic          Done;
  logic          Timeout;
  logic [1:0]    ProgIdx;
  logic [15:0]   CycleCount;

  logic [L-1:0]  halt_addr = '1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_start[$];
  done_t      exp_done[$];

  always #5 Clk = ~Clk;

  prog_sequencer #(
    .L(10), .W(9), .NPROG(3),
    .BASE0(50), .BASE1(150), .BASE2(250), .BASE3(0),
    .HALT_OP(9'h1FF), .TIMEOUT(16'd20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Pc(Pc), .Instr(Instr),
    .PcLoad(PcLoad), .PcTarget(PcTarget), .CoreEn(CoreEn),
    .Done(Done), .Timeout(Timeout), .ProgIdx(ProgIdx), .CycleCount(CycleCount)
  );

  // Program counter model: absolute load wins over increment.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset)      Pc <= '0;
    else if (PcLoad) Pc <= PcTarget;
    else if (CoreEn) Pc <= Pc + 10'd1;
  end

  assign Instr = (Pc == halt_addr) ? HALT : 9'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: RUN entry checks the start PC, Done rise checks status.
  logic  prev_en   = 1'b0;
  logic  prev_done = 1'b0;
  done_t mon_d;
  logic [9:0] mon_s;

  always @(negedge Clk) begin
    if (CoreEn && !prev_en) begin
      if (exp_start.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_start: unexpected RUN entry at Pc=%0d", Pc);
      end else begin
        mon_s = exp_start.pop_front();
        check("run_start_pc", 32'(Pc), 32'(mon_s));
      end
    end
    if (Done && !prev_done) begin
      if (exp_done.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_rise: unexpected Done at Pc=%0d", Pc);
      end else begin
        mon_d = exp_done.pop_front();
        check("done_progidx", 32'(ProgIdx),    32'(mon_d.idx));
        check("done_cycles",  32'(CycleCount), 32'(mon_d.cc));
        check("done_pc",      32'(Pc),         32'(mon_d.pc));
        check("done_timeout", 32'(Timeout),    32'(mon_d.to));
      end
    end
    prev_en   = CoreEn;
    prev_done = Done;
  end

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!Done && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    check("wait_done", 32'(Done), 32'd1);
  endtask

  task automatic wait_pc(input logic [L-1:0] val, input int maxc);
    int n;
    n = 0;
    while (Pc != val && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    check("wait_pc", 32'(Pc), 32'(val));
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_pcload",   32'(PcLoad),     32'd0);
    check("rst_target",   32'(PcTarget),   32'd0);
    check("rst_coreen",   32'(CoreEn),     32'd0);
    check("rst_done",     32'(Done),       32'd0);
    check("rst_timeout",  32'(Timeout),    32'd0);
    check("rst_progidx",  32'(ProgIdx),    32'd0);
    check("rst_cycles",   32'(CycleCount), 32'd0);
    Reset = 1'b1;

    // Program 0: Start held 3 edges, halt at 60.
    halt_addr = 10'd60;
    exp_start.push_back(10'd50);
    exp_done.push_back('{2'd1, 16'd11, 10'd60, 1'b0});
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk);
    check("armed_pcload", 32'(PcLoad),   32'd1);
    check("armed_target", 32'(PcTarget), 32'd50);
    @(negedge Clk);
    check("armed_pc",     32'(Pc),       32'd50);
    @(negedge Clk); Start = 1'b0;
    wait_done(40);
    repeat (3) @(negedge Clk);
    check("halt_pc_frozen", 32'(Pc),     32'd60);
    check("done_held",      32'(Done),   32'd1);
    check("done_coreen",    32'(CoreEn), 32'd0);

    // Programs 1 and 2 back to back.
    halt_addr = 10'd153;
    exp_start.push_back(10'd150);
    exp_done.push_back('{2'd2, 16'd4, 10'd153, 1'b0});
    pulse_start();
    wait_done(40);
    halt_addr = 10'd250;
    exp_start.push_back(10'd250);
    exp_done.push_back('{2'd0, 16'd1, 10'd250, 1'b0});
    pulse_start();
    wait_done(40);

    // Wrap to program 0, abort at 57, restart same program.
    halt_addr = 10'd60;
    exp_start.push_back(10'd50);
    exp_start.push_back(10'd50);
    exp_done.push_back('{2'd1, 16'd11, 10'd60, 1'b0});
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk);
    check("wrap_target", 32'(PcTarget), 32'd50);
    Start = 1'b0;
    wait_pc(10'd57, 40);
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    check("abort_pc",      32'(Pc),      32'd50);
    check("abort_progidx", 32'(ProgIdx), 32'd0);
    check("abort_done",    32'(Done),    32'd0);
    check("abort_coreen",  32'(CoreEn),  32'd0);
    Start = 1'b0;
    wait_done(40);

    // Halt and Start in the same RUN cycle (program 1).
    halt_addr = 10'd155;
    exp_start.push_back(10'd150);
    exp_done.push_back('{2'd2, 16'd6, 10'd155, 1'b0});
    pulse_start();
    wait_pc(10'd155, 40);
    Start = 1'b1;
    @(negedge Clk);
    check("hs_done",    32'(Done),    32'd1);
    check("hs_progidx", 32'(ProgIdx), 32'd2);
    @(negedge Clk);
    check("hs_armed_done",   32'(Done),     32'd0);
    check("hs_armed_pcload", 32'(PcLoad),   32'd1);
    check("hs_armed_target", 32'(PcTarget), 32'd250);
    @(negedge Clk);
    check("hs_pc", 32'(Pc), 32'd250);
    halt_addr = 10'd250;
    exp_start.push_back(10'd250);
    exp_done.push_back('{2'd0, 16'd1, 10'd250, 1'b0});
    Start = 1'b0;
    wait_done(40);

    // Reset in the middle of program 1.
    halt_addr = 10'd52;
    exp_start.push_back(10'd50);
    exp_done.push_back('{2'd1, 16'd3, 10'd52, 1'b0});
    pulse_start();
    wait_done(40);
    halt_addr = '1;
    exp_start.push_back(10'd150);
    pulse_start();
    wait_pc(10'd153, 40);
    #2 Reset = 1'b0;
    #1;
    check("mrst_pcload",  32'(PcLoad),     32'd0);
    check("mrst_target",  32'(PcTarget),   32'd0);
    check("mrst_coreen",  32'(CoreEn),     32'd0);
    check("mrst_done",    32'(Done),       32'd0);
    check("mrst_timeout", 32'(Timeout),    32'd0);
    check("mrst_progidx", 32'(ProgIdx),    32'd0);
    check("mrst_cycles",  32'(CycleCount), 32'd0);
    @(negedge Clk); Reset = 1'b1;
    halt_addr = 10'd50;
    exp_start.push_back(10'd50);
    exp_done.push_back('{2'd1, 16'd1, 10'd50, 1'b0});
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk);
    check("post_rst_target", 32'(PcTarget), 32'd50);
    Start = 1'b0;
    wait_done(40);

    // Watchdog run on program 1, no halt.
    halt_addr = '1;
    exp_start.push_back(10'd150);
`ifdef SEQ_TIMEOUT_EN
    exp_done.push_back('{2'd2, 16'd20, 10'd170, 1'b1});
    pulse_start();
    wait_done(60);
    check("wd_timeout", 32'(Timeout), 32'd1);
    check("wd_coreen",  32'(CoreEn),  32'd0);
`else
    pulse_start();
    repeat (30) @(negedge Clk);
    check("nowd_coreen",  32'(CoreEn),  32'd1);
    check("nowd_timeout", 32'(Timeout), 32'd0);
    check("nowd_done",    32'(Done),    32'd0);
`endif

    repeat (3) @(negedge Clk);
    check("sb_drain", 32'(exp_start.size() + exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
